// File: rtl/cvp14_pkg.sv
// Shared CVP14 definitions: word and bus widths, and the boot loader state encoding.
package cvp14_pkg;

  localparam int WORD_W = 16;
  localparam int CPU_AW = 16;

  typedef enum logic [1:0] {
    BOOT_CLEAR = 2'd0,
    BOOT_LOAD  = 2'd1,
    BOOT_RUN   = 2'd2
  } boot_state_t;

endpackage

// File: rtl/cvp14_sram.sv
// Single-port synchronous RAM, DEPTH x WORD_W, with a registered read port.
module cvp14_sram
  import cvp14_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              Clk1,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Read data only updates on a read strobe, so it holds between core reads.
  always_ff @(posedge Clk1) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cvp14_mem_boot.sv
// CVP14 unified memory with boot loader: clear, load a host image, then serve the core.
module cvp14_mem_boot
  import cvp14_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int AW       = 10,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic              LdValid,
  input  logic [WORD_W-1:0] LdData,
  input  logic              LdLast,
  output logic              LdReady,
  output logic              CpuReset,
  input  logic [CPU_AW-1:0] Addr,
  input  logic              RD,
  input  logic              WR,
  input  logic [WORD_W-1:0] dataOut,
  output logic [WORD_W-1:0] DataIn,
  input  logic              V,
  output logic              BootDone,
  output logic              LdOverrun,
  output logic              BusErr,
  output logic              OvfSeen
);

  localparam logic [AW-1:0]   LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [CPU_AW:0] DEPTH_EXT = (CPU_AW + 1)'(DEPTH);
  localparam boot_state_t     ST_INIT   = CLEAR_EN ? BOOT_CLEAR : BOOT_LOAD;

  boot_state_t       state, state_nxt;
  logic [AW-1:0]     ptr;
  logic              in_range, run, ld_beat, cpu_rd, cpu_wr, rd_zero;
  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;

  assign in_range = ({1'b0, Addr} < DEPTH_EXT);
  assign run      = (state == BOOT_RUN);
  assign ld_beat  = (state == BOOT_LOAD) && LdValid;
  assign cpu_rd   = run && RD && !WR;
  assign cpu_wr   = run && WR;

  // Next state, decoded outputs and RAM port ownership
  always_comb begin
    state_nxt = state;
    LdReady   = 1'b0;
    CpuReset  = 1'b1;
    BootDone  = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = ptr;
    ram_wdata = '0;
    unique case (state)
      BOOT_CLEAR: begin
        ram_we = !Reset;
        if (ptr == LAST_IDX) state_nxt = BOOT_LOAD;
      end
      BOOT_LOAD: begin
        LdReady   = 1'b1;
        ram_we    = ld_beat && !Reset;
        ram_wdata = LdData;
        if (ld_beat && (LdLast || ptr == LAST_IDX)) state_nxt = BOOT_RUN;
      end
      BOOT_RUN: begin
        CpuReset  = 1'b0;
        BootDone  = 1'b1;
        ram_addr  = Addr[AW-1:0];
        ram_wdata = dataOut;
        ram_we    = cpu_wr && in_range && !Reset;
        ram_re    = cpu_rd && in_range && !Reset;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state     <= ST_INIT;
      ptr       <= '0;
      LdOverrun <= 1'b0;
      BusErr    <= 1'b0;
      OvfSeen   <= 1'b0;
      rd_zero   <= 1'b1;
    end else begin
      state <= state_nxt;
      // Pointer wraps to 0 after the last word, which is where LOAD must start.
      if (state == BOOT_CLEAR || ld_beat) ptr <= ptr + 1'b1;
      if (ld_beat && ptr == LAST_IDX && !LdLast) LdOverrun <= 1'b1;
      if (run && (RD || WR) && (!in_range || (RD && WR))) BusErr <= 1'b1;
      if (run && V) OvfSeen <= 1'b1;
      if (cpu_rd) rd_zero <= !in_range;
    end
  end

  // An out-of-range read (or reset) presents zero without touching the RAM.
  assign DataIn = rd_zero ? '0 : ram_rdata;

  cvp14_sram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_sram (
    .Clk1 (Clk1),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .rdata(ram_rdata)
  );

endmodule
